// File: rtl/uart_port_bridge.sv
// ============================================================================
// uart_port_bridge
//
// Host-side initiator for the 8-bit port bus. Command frames arrive as bytes
// from a UART receiver. Each complete frame produces exactly one write or read
// strobe on the port bus. The bridge then hands an acknowledge byte, or the
// byte read back, to the UART transmitter. A PC can use it to drive
// peripherals without the soft processor running.
//
// Frames:
//   write : 'W'(8'h57) addr_hi addr_lo data
//   read  : 'R'(8'h52) addr_hi addr_lo
//
// Optional build macro PORT_BRIDGE_CHECKSUM_EN:
//   Every frame carries one extra trailing byte. That byte must equal the
//   XOR of all preceding frame bytes. A mismatch is answered with NAK_BYTE
//   and no strobe is issued. Without the macro, frames are exactly as shown
//   above.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles allowed between bytes of one frame (1..65535)
//   ACK_BYTE        response after a completed write
//   NAK_BYTE        response to a bad command (or bad checksum)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous reset, active-high
//   rx_data       received byte, valid while rx_valid is high
//   rx_valid      one-cycle pulse per received byte
//   tx_data       response byte
//   tx_valid      response available, held until tx_ready
//   tx_ready      transmitter accepts tx_data when tx_valid & tx_ready
//   port_id       port bus address
//   out_port      port bus write data
//   in_port       port bus read data
//   write_strobe  one-cycle write strobe
//   read_strobe   one-cycle read strobe
//   busy          high whenever the FSM is not in IDLE
//   err           one-cycle pulse on bad command, timeout or overrun
//
// Timing:
//   The last frame byte is accepted on edge N. The FSM enters WSTB/RSTB on
//   that edge. The strobe output is a register fed from the state, so it is
//   high from edge N+1 to edge N+2. Because of this, port_id and out_port
//   have already been stable for a full cycle when the strobe rises. The
//   response byte is loaded on the edge that ends the strobe, so tx_valid
//   rises at edge N+2.
// ============================================================================
module uart_port_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] port_id,
    output logic [7:0]  out_port,
    input  logic [7:0]  in_port,
    output logic        write_strobe,
    output logic        read_strobe,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0]  CMD_WRITE    = 8'h57;
    localparam logic [7:0]  CMD_READ     = 8'h52;
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR_H = 3'd1,
        ADDR_L = 3'd2,
        DATA   = 3'd3,
`ifdef PORT_BRIDGE_CHECKSUM_EN
        CSUM   = 3'd4,
`endif
        WSTB   = 3'd5,
        RSTB   = 3'd6,
        RESP   = 3'd7
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        is_write;
    logic        next_is_write;
    logic [15:0] timeout_cnt;
    logic [15:0] next_timeout_cnt;
    logic [15:0] next_port_id;
    logic [7:0]  next_out_port;
    logic [7:0]  next_tx_data;
    logic        next_err;
    logic        waiting_byte;
    logic        timeout_hit;
`ifdef PORT_BRIDGE_CHECKSUM_EN
    logic [7:0]  csum_acc;
    logic [7:0]  next_csum_acc;
`endif

    // The frame timer only runs while we are partway through a frame and
    // waiting for its next byte. An abort is raised on the cycle in which
    // the count would reach TIMEOUT_CYCLES without a byte arriving.
    always_comb begin
        waiting_byte = (state == ADDR_H) || (state == ADDR_L) || (state == DATA);
`ifdef PORT_BRIDGE_CHECKSUM_EN
        if (state == CSUM) begin
            waiting_byte = 1'b1;
        end
`endif
        timeout_hit = waiting_byte && !rx_valid && (timeout_cnt == TIMEOUT_LAST);
    end

    // Next-state and next-register logic. Every registered value defaults
    // to holding its current value. Only byte captures and response loads
    // change port_id, out_port and tx_data.
    always_comb begin
        next_state       = state;
        next_is_write    = is_write;
        next_port_id     = port_id;
        next_out_port    = out_port;
        next_tx_data     = tx_data;
        next_err         = 1'b0;
        next_timeout_cnt = 16'd0;
`ifdef PORT_BRIDGE_CHECKSUM_EN
        next_csum_acc    = csum_acc;
`endif

        if (waiting_byte) begin
            next_timeout_cnt = rx_valid ? 16'd0 : timeout_cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) begin
                        next_is_write = (rx_data == CMD_WRITE);
                        next_state    = ADDR_H;
`ifdef PORT_BRIDGE_CHECKSUM_EN
                        next_csum_acc = rx_data;
`endif
                    end else begin
                        next_err     = 1'b1;
                        next_tx_data = NAK_BYTE;
                        next_state   = RESP;
                    end
                end
            end

            ADDR_H: begin
                if (rx_valid) begin
                    next_port_id[15:8] = rx_data;
                    next_state         = ADDR_L;
`ifdef PORT_BRIDGE_CHECKSUM_EN
                    next_csum_acc      = csum_acc ^ rx_data;
`endif
                end
            end

            ADDR_L: begin
                if (rx_valid) begin
                    next_port_id[7:0] = rx_data;
`ifdef PORT_BRIDGE_CHECKSUM_EN
                    next_csum_acc     = csum_acc ^ rx_data;
                    next_state        = is_write ? DATA : CSUM;
`else
                    next_state        = is_write ? DATA : RSTB;
`endif
                end
            end

            DATA: begin
                if (rx_valid) begin
                    next_out_port = rx_data;
`ifdef PORT_BRIDGE_CHECKSUM_EN
                    next_csum_acc = csum_acc ^ rx_data;
                    next_state    = CSUM;
`else
                    next_state    = WSTB;
`endif
                end
            end

`ifdef PORT_BRIDGE_CHECKSUM_EN
            // The trailing byte must equal the XOR of all earlier frame bytes.
            // If it does not, the frame is answered with NAK and no strobe.
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_acc) begin
                        next_state = is_write ? WSTB : RSTB;
                    end else begin
                        next_err     = 1'b1;
                        next_tx_data = NAK_BYTE;
                        next_state   = RESP;
                    end
                end
            end
`endif

            WSTB: begin
                next_err   = rx_valid;
                next_state = RESP;
            end

            RSTB: begin
                next_err   = rx_valid;
                next_state = RESP;
            end

            RESP: begin
                next_err = rx_valid;
                if (tx_valid && tx_ready) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase

        // timeout_hit can only be true in a waiting state with no byte this
        // cycle, so it never competes with a byte capture above.
        if (timeout_hit) begin
            next_err   = 1'b1;
            next_state = IDLE;
        end

        // The strobe cycle itself has already moved the FSM into RESP. The
        // response byte is loaded on the edge that closes the strobe. For a
        // read, in_port is sampled exactly while read_strobe is high.
        if (write_strobe) begin
            next_tx_data = ACK_BYTE;
        end else if (read_strobe) begin
            next_tx_data = in_port;
        end
    end

    // State register together with the frame bookkeeping. This includes the
    // command type, the inter-byte timer and the running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            is_write    <= 1'b0;
            timeout_cnt <= 16'd0;
`ifdef PORT_BRIDGE_CHECKSUM_EN
            csum_acc    <= 8'd0;
`endif
        end else begin
            state       <= next_state;
            is_write    <= next_is_write;
            timeout_cnt <= next_timeout_cnt;
`ifdef PORT_BRIDGE_CHECKSUM_EN
            csum_acc    <= next_csum_acc;
`endif
        end
    end

    // Registered bus and UART outputs.
    // - Strobes follow the state one cycle late, giving the address and data
    //   a full cycle of setup before the strobe.
    // - tx_valid drops on the accepting edge.
    // - busy tracks the state the FSM is entering.
    always_ff @(posedge clk) begin
        if (rst) begin
            port_id      <= 16'd0;
            out_port     <= 8'd0;
            tx_data      <= 8'd0;
            tx_valid     <= 1'b0;
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            port_id      <= next_port_id;
            out_port     <= next_out_port;
            tx_data      <= next_tx_data;
            tx_valid     <= (state == RESP) && !(tx_valid && tx_ready);
            write_strobe <= (state == WSTB);
            read_strobe  <= (state == RSTB);
            busy         <= (next_state != IDLE);
            err          <= next_err;
        end
    end

endmodule

// File: tb/tb_uart_port_bridge.sv
// ============================================================================
// tb_uart_port_bridge
//
// Self-checking bench for uart_port_bridge, built with TIMEOUT_CYCLES = 16.
// The stimulus tasks push expected strobes and response bytes into queues.
// Monitors pop those queues when the bridge strobes the port bus, or when a
// response byte is handed over. Directed checks cover cycle-exact latency,
// tx hold, bad commands, timeout, overrun and mid-frame reset.
// Compile with PORT_BRIDGE_CHECKSUM_EN to exercise checksummed frames.
// ============================================================================
module tb_uart_port_bridge;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] port_id;
    logic [7:0]  out_port;
    logic [7:0]  in_port;
    logic        write_strobe;
    logic        read_strobe;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } strobe_t;

    strobe_t    exp_stb_q[$];
    logic [7:0] exp_tx_q[$];

    int compared   = 0;
    int mismatched = 0;

    uart_port_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .port_id     (port_id),
        .out_port    (out_port),
        .in_port     (in_port),
        .write_strobe(write_strobe),
        .read_strobe (read_strobe),
        .busy        (busy),
        .err         (err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Counts every comparison and reports each mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drives one received byte for one cycle.
    // Returns 1 ns after the edge that accepted the byte.
    task automatic applyStimulus(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Sends a write frame and queues the expected strobe and ACK.
    task automatic sendWrite(input logic [15:0] addr, input logic [7:0] data);
        exp_stb_q.push_back('{wr: 1'b1, addr: addr, data: data});
        exp_tx_q.push_back(8'h06);
        applyStimulus(8'h57);
        applyStimulus(addr[15:8]);
        applyStimulus(addr[7:0]);
        applyStimulus(data);
`ifdef PORT_BRIDGE_CHECKSUM_EN
        applyStimulus(8'h57 ^ addr[15:8] ^ addr[7:0] ^ data);
`endif
    endtask

    // Sends a read frame. The returned byte is whatever in_port holds.
    task automatic sendRead(input logic [15:0] addr, input logic [7:0] rdata);
        exp_stb_q.push_back('{wr: 1'b0, addr: addr, data: 8'h00});
        exp_tx_q.push_back(rdata);
        in_port = rdata;
        applyStimulus(8'h52);
        applyStimulus(addr[15:8]);
        applyStimulus(addr[7:0]);
`ifdef PORT_BRIDGE_CHECKSUM_EN
        applyStimulus(8'h52 ^ addr[15:8] ^ addr[7:0]);
`endif
    endtask

    // Waits a bounded number of cycles for busy to fall.
    // An expired bound shows up as a failed comparison.
    task automatic waitIdle(input string tag);
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(tag, busy, 0);
    endtask

    // Scoreboard monitors, sampled at the falling edge away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (write_strobe && read_strobe) begin
                checkOutput("strobe_exclusive", 1'b1, 0);
            end
            if (write_strobe || read_strobe) begin
                if (exp_stb_q.size() == 0) begin
                    checkOutput("stb_unexpected", {write_strobe, read_strobe}, 0);
                end else begin
                    strobe_t e;
                    e = exp_stb_q.pop_front();
                    checkOutput("stb_write", write_strobe, e.wr);
                    checkOutput("stb_read", read_strobe, !e.wr);
                    checkOutput("stb_port_id", port_id, e.addr);
                    if (e.wr) begin
                        checkOutput("stb_out_port", out_port, e.data);
                    end
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) begin
                    checkOutput("tx_unexpected", tx_valid, 0);
                end else begin
                    checkOutput("tx_data", tx_data, exp_tx_q.pop_front());
                end
            end
        end
    end

    initial begin
        int early_err;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        in_port  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_tx_valid", tx_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_strobes", {write_strobe, read_strobe, err}, 0);
        checkOutput("rst_port_id", port_id, 0);
        checkOutput("rst_data", {out_port, tx_data}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Write with cycle-exact latency checks.
        sendWrite(16'h1234, 8'hA5);
        checkOutput("wr_n_strobe", write_strobe, 0);
        checkOutput("wr_n_port_id", port_id, 16'h1234);
        checkOutput("wr_n_out_port", out_port, 8'hA5);
        @(posedge clk);
        #1;
        checkOutput("wr_n1_strobe", write_strobe, 1);
        checkOutput("wr_n1_read_strobe", read_strobe, 0);
        checkOutput("wr_n1_tx_valid", tx_valid, 0);
        @(posedge clk);
        #1;
        checkOutput("wr_n2_strobe", write_strobe, 0);
        checkOutput("wr_n2_tx_valid", tx_valid, 1);
        checkOutput("wr_n2_tx_data", tx_data, 8'h06);
        waitIdle("wr_idle");

        // Read with the transmitter stalled for five cycles.
        tx_ready = 1'b0;
        sendRead(16'h0003, 8'h5C);
        @(posedge clk);
        #1;
        checkOutput("rd_n1_strobe", read_strobe, 1);
        checkOutput("rd_n1_port_id", port_id, 16'h0003);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("rd_hold_valid", tx_valid, 1);
            checkOutput("rd_hold_data", tx_data, 8'h5C);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rd_done_valid", tx_valid, 0);
        waitIdle("rd_idle");

        // Bad command byte.
        exp_tx_q.push_back(8'h15);
        applyStimulus(8'h41);
        checkOutput("bad_err", err, 1);
        checkOutput("bad_tx_data", tx_data, 8'h15);
        checkOutput("bad_busy", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("bad_err_pulse", err, 0);
        waitIdle("bad_idle");

        // Timeout after a partial frame.
        applyStimulus(8'h57);
        applyStimulus(8'h12);
        early_err = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            @(posedge clk);
            #1;
            if (err) early_err++;
        end
        checkOutput("to_early_err", early_err, 0);
        checkOutput("to_busy_before", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("to_err", err, 1);
        checkOutput("to_busy_after", busy, 0);
        sendRead(16'h0001, 8'h3C);
        waitIdle("to_next_idle");

        // Overrun while the response is pending.
        tx_ready = 1'b0;
        sendWrite(16'hABCD, 8'h01);
        for (int i = 0; i < 20 && !tx_valid; i++) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(8'h99);
        checkOutput("ovr_err", err, 1);
        checkOutput("ovr_tx_valid", tx_valid, 1);
        checkOutput("ovr_tx_data", tx_data, 8'h06);
        tx_ready = 1'b1;
        waitIdle("ovr_idle");

        // Reset while in ADDR_L.
        applyStimulus(8'h57);
        applyStimulus(8'h77);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_port_id", port_id, 0);
        checkOutput("mid_rst_flags", {tx_valid, write_strobe, read_strobe, busy, err}, 0);
        checkOutput("mid_rst_data", {out_port, tx_data}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sendWrite(16'h0005, 8'h77);
        waitIdle("post_rst_idle");

`ifdef PORT_BRIDGE_CHECKSUM_EN
        // Raw checksum frames: good, then bad.
        exp_stb_q.push_back('{wr: 1'b1, addr: 16'h0001, data: 8'hFF});
        exp_tx_q.push_back(8'h06);
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'hFF);
        applyStimulus(8'hA9);
        waitIdle("csum_good_idle");
        exp_tx_q.push_back(8'h15);
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'hFF);
        applyStimulus(8'h00);
        checkOutput("csum_bad_err", err, 1);
        checkOutput("csum_bad_tx_data", tx_data, 8'h15);
        waitIdle("csum_bad_idle");
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("stb_queue_left", exp_stb_q.size(), 0);
        checkOutput("tx_queue_left", exp_tx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
